// File: rtl/bcd_serial_add_seq.sv
// Digit-serial packed-BCD adder sequencer: drives an external single-digit BCD adder LSD first.
// Latency: result valid DIGITS cycles after accept; one add per DIGITS+2 cycles without backpressure.
// Backpressure: in_ready low while busy; result holds in DONE until out_ready. Option macro: BCD_DIGIT_CHECK_EN.
module bcd_serial_add_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    input  logic                  cin,
    output logic [3:0]            dig_a,
    output logic [3:0]            dig_b,
    output logic                  dig_cin,
    input  logic [3:0]            dig_sum,
    input  logic                  dig_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum_bcd,
    output logic                  cout,
    output logic                  busy
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic [IW-1:0]       idx;
    logic                carry;
    logic [3:0]          cur_a;
    logic [3:0]          cur_b;

    // Select the operand digits addressed by idx from the latched operands only.
    always_comb begin
        cur_a = 4'd0;
        cur_b = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_a = a_q[i*4 +: 4];
                cur_b = b_q[i*4 +: 4];
            end
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic nibble_bad;

    // Flag any non-decimal nibble on the incoming operands.
    always_comb begin
        nibble_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_bcd[i*4 +: 4] > 4'd9 || b_bcd[i*4 +: 4] > 4'd9) begin
                nibble_bad = 1'b1;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; dig_* only depend on registered state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        dig_a     = 4'd0;
        dig_b     = 4'd0;
        dig_cin   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                dig_a   = cur_a;
                dig_b   = cur_b;
                dig_cin = carry;
                if (idx == LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture operands at accept, collect one sum digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            sum_bcd <= '0;
            cout    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_bcd;
                        b_q     <= b_bcd;
                        carry   <= cin;
                        idx     <= '0;
                        sum_bcd <= '0;
                        cout    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                        err     <= nibble_bad;
`endif
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) begin
                            sum_bcd[i*4 +: 4] <= dig_sum;
                        end
                    end
                    carry <= dig_cout;
                    // idx parks on the last digit rather than wrapping.
                    if (idx == LAST) begin
                        cout <= dig_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
`ifdef BCD_DIGIT_CHECK_EN
                    if (out_ready) begin
                        err <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_seq.sv
// Self-checking bench for bcd_serial_add_seq with a behavioural digit adder.
// Reference sums come from decimal integer arithmetic on the operands.
// Covers reset, directed/random adds, hold in DONE, abort, throughput and the digit check.
module tb_bcd_serial_add_seq;

    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [4*D-1:0] a_bcd;
    logic [4*D-1:0] b_bcd;
    logic           cin;
    logic [3:0]     dig_a;
    logic [3:0]     dig_b;
    logic           dig_cin;
    logic [3:0]     dig_sum;
    logic           dig_cout;
    logic           out_valid;
    logic           out_ready;
    logic [4*D-1:0] sum_bcd;
    logic           cout;
    logic           busy;
`ifdef BCD_DIGIT_CHECK_EN
    logic           err;
    logic           err_q;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_add_seq #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_bcd    (a_bcd),
        .b_bcd    (b_bcd),
        .cin      (cin),
        .dig_a    (dig_a),
        .dig_b    (dig_b),
        .dig_cin  (dig_cin),
        .dig_sum  (dig_sum),
        .dig_cout (dig_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_bcd  (sum_bcd),
        .cout     (cout),
        .busy     (busy)
`ifdef BCD_DIGIT_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    // Single-digit BCD adder model.
    logic [4:0] dig_tmp;
    always_comb begin
        dig_tmp = 5'(dig_a) + 5'(dig_b) + 5'(dig_cin);
        if (dig_tmp > 5'd9) begin
            dig_cout = 1'b1;
            dig_sum  = 4'(dig_tmp - 5'd10);
        end else begin
            dig_cout = 1'b0;
            dig_sum  = dig_tmp[3:0];
        end
    end

    function automatic longint bcd2int(input logic [4*D-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [4*D-1:0] int2bcd(input longint x);
        logic [4*D-1:0] r = '0;
        longint t = x;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4*D-1:0] rand_bcd();
        logic [4*D-1:0] r;
        for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Decimal reference: whole-number add, then split into D digits and carry.
    function automatic void ref_add(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                                    input logic c, output logic [4*D-1:0] s, output logic co);
        longint pw = 1;
        longint t;
        for (int i = 0; i < D; i++) pw = pw * 10;
        t  = bcd2int(a) + bcd2int(b) + longint'(c);
        s  = int2bcd(t % pw);
        co = (t >= pw);
    endfunction

    // Drive one add from IDLE, wait (bounded) for the result, then handshake it.
    task automatic run_add(input logic [4*D-1:0] a, input logic [4*D-1:0] b, input logic c,
                           output logic [4*D-1:0] s, output logic co, output int lat,
                           output bit timeout);
        @(negedge clk);
        a_bcd = a; b_bcd = b; cin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        timeout = !out_valid;
        s  = sum_bcd;
        co = cout;
`ifdef BCD_DIGIT_CHECK_EN
        err_q = err;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_bcd = '0; b_bcd = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        n_checks++; if (sum_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset sum_bcd got %h want 0000", sum_bcd); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset cout got %b want 0", cout); end
        n_checks++; if ({dig_a, dig_b, dig_cin} !== 9'd0) begin n_fail++; $display("FAIL reset dig_* got %h/%h/%b want 0", dig_a, dig_b, dig_cin); end
`ifdef BCD_DIGIT_CHECK_EN
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset err got %b want 0", err); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [4*D-1:0] va [4] = '{16'h1234, 16'h9999, 16'h0000, 16'h4999};
        logic [4*D-1:0] vb [4] = '{16'h5678, 16'h0001, 16'h0000, 16'h5000};
        logic           vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [4*D-1:0] es [4] = '{16'h6912, 16'h0000, 16'h0001, 16'h0000};
        logic           ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4*D-1:0] s;
        logic co;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            run_add(va[i], vb[i], vc[i], s, co, lat, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL directed%0d timeout waiting for out_valid", i); end
            n_checks++; if (lat != D) begin n_fail++; $display("FAIL directed%0d latency got %0d want %0d", i, lat, D); end
            n_checks++; if (s !== es[i]) begin n_fail++; $display("FAIL directed%0d sum got %h want %h", i, s, es[i]); end
            n_checks++; if (co !== ec[i]) begin n_fail++; $display("FAIL directed%0d cout got %b want %b", i, co, ec[i]); end
        end
    endtask

    task automatic test_random();
        logic [4*D-1:0] a, b, s, es;
        logic c, co, ec;
        int lat;
        bit to;
        for (int i = 0; i < 25; i++) begin
            a = rand_bcd(); b = rand_bcd(); c = 1'($urandom_range(0, 1));
            ref_add(a, b, c, es, ec);
            run_add(a, b, c, s, co, lat, to);
            n_checks++; if (to || lat != D) begin n_fail++; $display("FAIL random%0d latency got %0d (timeout %0d) want %0d", i, lat, to, D); end
            n_checks++; if ({co, s} !== {ec, es}) begin n_fail++; $display("FAIL random%0d %h+%h+%b got %b_%h want %b_%h", i, a, b, c, co, s, ec, es); end
        end
    endtask

    task automatic test_hold();
        int n;
        @(negedge clk);
        a_bcd = 16'h1234; b_bcd = 16'h5678; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold timeout out_valid got %b want 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d out_valid/in_ready got %b/%b want 1/0", i, out_valid, in_ready); end
            n_checks++; if ({cout, sum_bcd} !== {1'b0, 16'h6912}) begin n_fail++; $display("FAIL hold%0d result got %b_%h want 0_6912", i, cout, sum_bcd); end
            a_bcd = 16'h9999; b_bcd = 16'h9999; cin = 1'b1; in_valid = (i % 2 == 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold handshake-cycle in_ready got %b want 0", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hold after in_ready/out_valid/busy got %b/%b/%b want 1/0/0", in_ready, out_valid, busy); end
    endtask

    task automatic test_abort();
        logic [4*D-1:0] s;
        logic co;
        int lat;
        bit to;
        @(negedge clk);
        a_bcd = 16'h1234; b_bcd = 16'h5678; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({dig_a, dig_b, dig_cin} !== {4'h4, 4'h8, 1'b0}) begin n_fail++; $display("FAIL abort digit0 got %h/%h/%b want 4/8/0", dig_a, dig_b, dig_cin); end
        repeat (2) @(negedge clk);
        n_checks++; if ({dig_a, dig_b, dig_cin} !== {4'h2, 4'h6, 1'b1}) begin n_fail++; $display("FAIL abort digit2 got %h/%h/%b want 2/6/1", dig_a, dig_b, dig_cin); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort in_ready/out_valid/busy got %b/%b/%b want 1/0/0", in_ready, out_valid, busy); end
        n_checks++; if ({cout, sum_bcd} !== 17'd0) begin n_fail++; $display("FAIL abort result got %b_%h want 0_0000", cout, sum_bcd); end
        run_add(16'h0005, 16'h0004, 1'b0, s, co, lat, to);
        n_checks++; if (to || {co, s} !== {1'b0, 16'h0009}) begin n_fail++; $display("FAIL abort next add got %b_%h (timeout %0d) want 0_0009", co, s, to); end
    endtask

    task automatic test_back_to_back();
        logic [4*D:0] q [$];
        logic [4*D:0] ex;
        logic [4*D-1:0] es;
        logic ec;
        int cyc = 0, last = -1, nres = 0;
        @(negedge clk);
        a_bcd = rand_bcd(); b_bcd = rand_bcd(); cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1; out_ready = 1'b1;
        while (nres < 4 && cyc < 200) begin
            if (out_valid) begin
                ex = (q.size() > 0) ? q.pop_front() : 'x;
                n_checks++; if ({cout, sum_bcd} !== ex) begin n_fail++; $display("FAIL b2b result%0d got %b_%h want %h", nres, cout, sum_bcd, ex); end
                nres++;
                if (nres == 4) in_valid = 1'b0;
            end
            if (in_ready && in_valid) begin
                if (last >= 0) begin
                    n_checks++; if (cyc - last != D + 2) begin n_fail++; $display("FAIL b2b interval got %0d want %0d", cyc - last, D + 2); end
                end
                last = cyc;
                ref_add(a_bcd, b_bcd, cin, es, ec);
                q.push_back({ec, es});
            end else if (!in_ready) begin
                a_bcd = rand_bcd(); b_bcd = rand_bcd(); cin = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++; if (nres != 4) begin n_fail++; $display("FAIL b2b results got %0d want 4", nres); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef BCD_DIGIT_CHECK_EN
    task automatic test_err();
        logic [4*D-1:0] s;
        logic co;
        int lat;
        bit to;
        run_add(16'h00A0, 16'h0000, 1'b0, s, co, lat, to);
        n_checks++; if (to || err_q !== 1'b1) begin n_fail++; $display("FAIL err bad digit got %b (timeout %0d) want 1", err_q, to); end
        n_checks++; if (lat != D) begin n_fail++; $display("FAIL err latency got %0d want %0d", lat, D); end
        run_add(16'h0001, 16'h0001, 1'b0, s, co, lat, to);
        n_checks++; if (to || err_q !== 1'b0) begin n_fail++; $display("FAIL err legal add got %b want 0", err_q); end
        n_checks++; if ({co, s} !== {1'b0, 16'h0002}) begin n_fail++; $display("FAIL err legal sum got %b_%h want 0_0002", co, s); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_abort();
        test_back_to_back();
`ifdef BCD_DIGIT_CHECK_EN
        test_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
